// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and the data memory.
package dmem_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DMEM_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: among the unmasked requests,
// a single request wins outright and a tie goes to the pointer's requester.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] eligible;

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise an uncovered path holds its old value and infers a latch.
  always_comb begin
    eligible = req & mask;
    gnt      = 2'b00;
    case (eligible)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port data memory,
// with a per-requester lock for atomic read-modify-write and range checking.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] we_i,
  input  logic [NUM_REQ-1:0] lock_i,
  input  logic [N-1:0]       addr0_i,
  input  logic [N-1:0]       addr1_i,
  input  logic [N-1:0]       wdata0_i,
  input  logic [N-1:0]       wdata1_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  output logic               rsp_err_o,
  output logic [N-1:0]       rdata_o,
  output logic [N-1:0]       mem_addr_o,
  output logic [N-1:0]       mem_wdata_o,
  output logic               mem_we_o,
  input  logic [N-1:0]       mem_rdata_i
);

  localparam logic [N-1:0] DEPTH_N = N'(DEPTH);

  arb_state_t   state, state_next;
  logic         ptr;
  logic         arb_idle;
  logic [1:0]   mask;
  logic [1:0]   gnt_pick;
  logic         granted;
  logic         sel;
  logic [N-1:0] addr_sel;
  logic [N-1:0] wdata_sel;
  logic         we_sel;
  logic         in_range;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A lock that is still held restricts arbitration to its owner; the cycle
  // the owner drops lock_i already arbitrates as IDLE.
  always_comb begin
    arb_idle = 1'b1;
    mask     = 2'b11;
    case (state)
      LOCK0: if (lock_i[0]) begin arb_idle = 1'b0; mask = 2'b01; end
      LOCK1: if (lock_i[1]) begin arb_idle = 1'b0; mask = 2'b10; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    if (arb_idle) begin
      if (gnt_o[0] && lock_i[0])      state_next = LOCK0;
      else if (gnt_o[1] && lock_i[1]) state_next = LOCK1;
      else                            state_next = IDLE;
    end
  end

  rr_pick2 u_pick (
    .req  (req_i),
    .ptr  (ptr),
    .mask (mask),
    .gnt  (gnt_pick)
  );

  assign gnt_o     = rst_n ? gnt_pick : 2'b00;
  assign granted   = |gnt_o;
  assign sel       = gnt_o[1];
  assign addr_sel  = sel ? addr1_i  : addr0_i;
  assign wdata_sel = sel ? wdata1_i : wdata0_i;
  assign we_sel    = sel ? we_i[1]  : we_i[0];
  assign in_range  = addr_sel < DEPTH_N;

  assign mem_addr_o  = granted ? addr_sel  : '0;
  assign mem_wdata_o = granted ? wdata_sel : '0;
  assign mem_we_o    = granted & we_sel & in_range;

  // Pointer hands priority to the loser of each idle grant; frozen under lock.
  always_ff @(posedge clk) begin
    if (!rst_n)                  ptr <= 1'b0;
    else if (arb_idle && granted) ptr <= ~sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_o <= '0;
      rsp_err_o   <= 1'b0;
      rdata_o     <= '0;
    end else begin
      rsp_valid_o <= gnt_o;
      rsp_err_o   <= granted & ~in_range;
      rdata_o     <= (granted && !we_sel && in_range) ? mem_rdata_i : '0;
    end
  end

endmodule
